ps2_host_tx: RTL and testbench

//  Parametrised, fully Clk-synchronous PS/2 host-to-device transmitter (mouse command path).
//  - Performs request-to-send, shifts a byte with odd parity, checks device ACK, times out a

---
 rtl/ps2_host_tx.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, LSB-first byte with odd parity,
// device ACK check, per-edge timeout and automatic retries. Drives lines as pull-low enables only.

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic line_in,
    output logic level_out
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;

    // Two-stage synchronizer; idle bus level is high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], line_in};
        end
    end

    // Level follows the line only after FILTER_LEN consecutive opposite samples.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_r   <= '0;
            level_r <= 1'b1;
        end else if (sync_r[1] == level_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= sync_r[1];
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign level_out = level_r;

endmodule

module ps2_host_tx #(
    parameter int HOLD_CYCLES    = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Ps2ClkIn,
    input  logic       Ps2DataIn,
    output logic       Ps2ClkLowEn,
    output logic       Ps2DataLowEn,
    input  logic       Write,
    input  logic [7:0] Data,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [1:0] ErrCode
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRIES);

    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_NO_ACK  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FAIL
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    state_t        state_r;
    logic [9:0]    frame_r;
    logic [3:0]    bit_idx_r;
    logic [HW-1:0] hold_cnt_r;
    logic [TW-1:0] to_cnt_r;
    logic [RW-1:0] retry_r;
    logic [1:0]    fail_code_r;
    logic          clk_low_en_r;
    logic          data_low_en_r;
    logic          busy_r;
    logic          done_r;
    logic          error_r;
    logic [1:0]    err_code_r;
    logic          clk_filt_d_r;

    logic clk_filt_s;
    logic data_filt_s;
    logic clk_fall_s;
    logic clk_edge_s;
    logic to_active_s;
    logic to_hit_s;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .Clk       (Clk),
        .Reset     (Reset),
        .line_in   (Ps2ClkIn),
        .level_out (clk_filt_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .Clk       (Clk),
        .Reset     (Reset),
        .line_in   (Ps2DataIn),
        .level_out (data_filt_s)
    );

    // Previous filtered clock level for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_filt_d_r <= 1'b1;
        end else begin
            clk_filt_d_r <= clk_filt_s;
        end
    end

    assign clk_fall_s  = clk_filt_d_r & ~clk_filt_s;
    assign clk_edge_s  = clk_filt_d_r ^ clk_filt_s;
    assign to_active_s = (state_r == ST_RTS) || (state_r == ST_SHIFT) ||
                         (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);
    assign to_hit_s    = to_active_s && (to_cnt_r == TO_LAST) && !clk_edge_s;

    // Silent-device watchdog: restarts on every device clock edge and when RTS is entered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            to_cnt_r <= '0;
        end else if (!to_active_s || (state_r == ST_RTS) || clk_edge_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Transfer sequencer with registered line enables and status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r       <= ST_IDLE;
            frame_r       <= '0;
            bit_idx_r     <= 4'd0;
            hold_cnt_r    <= '0;
            retry_r       <= '0;
            fail_code_r   <= 2'b00;
            clk_low_en_r  <= 1'b0;
            data_low_en_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            err_code_r    <= 2'b00;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    clk_low_en_r  <= 1'b0;
                    data_low_en_r <= 1'b0;
                    // Busy drops one cycle after the Done/Error pulse; Write is ignored meanwhile.
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (Write) begin
                        frame_r      <= {1'b1, odd_parity(Data), Data};
                        busy_r       <= 1'b1;
                        err_code_r   <= 2'b00;
                        retry_r      <= '0;
                        hold_cnt_r   <= '0;
                        clk_low_en_r <= 1'b1;
                        state_r      <= ST_INHIBIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INHIBIT: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        clk_low_en_r  <= 1'b0;
                        data_low_en_r <= 1'b1;
                        state_r       <= ST_RTS;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end
                end
                ST_RTS: begin
                    bit_idx_r <= 4'd0;
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (to_hit_s) begin
                        clk_low_en_r  <= 1'b0;
                        data_low_en_r <= 1'b0;
                        fail_code_r   <= CODE_TIMEOUT;
                        state_r       <= ST_FAIL;
                    end else if (clk_fall_s) begin
                        data_low_en_r <= ~frame_r[bit_idx_r];
                        if (bit_idx_r == 4'd9) begin
                            state_r <= ST_ACK;
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_ACK: begin
                    if (to_hit_s) begin
                        fail_code_r <= CODE_TIMEOUT;
                        state_r     <= ST_FAIL;
                    end else if (clk_fall_s) begin
                        if (!data_filt_s) begin
                            state_r <= ST_WAIT_IDLE;
                        end else begin
                            fail_code_r <= CODE_NO_ACK;
                            state_r     <= ST_FAIL;
                        end
                    end else begin
                        state_r <= ST_ACK;
                    end
                    clk_low_en_r  <= 1'b0;
                    data_low_en_r <= 1'b0;
                end
                ST_WAIT_IDLE: begin
                    if (to_hit_s) begin
                        fail_code_r <= CODE_TIMEOUT;
                        state_r     <= ST_FAIL;
                    end else if (clk_filt_s && data_filt_s) begin
                        done_r  <= 1'b1;
                        retry_r <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                ST_FAIL: begin
                    data_low_en_r <= 1'b0;
                    if (retry_r < MAX_RETRY_C) begin
                        retry_r      <= retry_r + 1'b1;
                        hold_cnt_r   <= '0;
                        clk_low_en_r <= 1'b1;
                        state_r      <= ST_INHIBIT;
                    end else begin
                        clk_low_en_r <= 1'b0;
                        error_r      <= 1'b1;
                        err_code_r   <= fail_code_r;
                        retry_r      <= '0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    clk_low_en_r  <= 1'b0;
                    data_low_en_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ps2ClkLowEn  = clk_low_en_r;
    assign Ps2DataLowEn = data_low_en_r;
    assign Busy         = busy_r;
    assign Done         = done_r;
    assign Error        = error_r;
    assign ErrCode      = err_code_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out over a
// wired-AND bus model and checks bits, ACK handling, retries, timeout and reset.

module tb_ps2_host_tx;

    localparam int H = 40;

    logic       Clk;
    logic       Reset;
    logic       Write;
    logic [7:0] Data;
    logic       Ps2ClkLowEn;
    logic       Ps2DataLowEn;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [1:0] ErrCode;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_s;
    logic       ps2_data_s;

    int tests_run;
    int tests_failed;
    int done_cnt;
    int err_cnt;
    int attempt_cnt;
    int inh_cnt;
    int last_inhibit_len;
    int busy_gap;
    logic [1:0] last_err_code;
    logic prev_clk_en;
    logic data_at_release;
    logic in_xfer;
    logic [10:0] bits_v;
    bit ok_v;

    assign ps2_clk_s  = ~(Ps2ClkLowEn | dev_clk_low);
    assign ps2_data_s = ~(Ps2DataLowEn | dev_data_low);

    ps2_host_tx #(
        .HOLD_CYCLES    (5000),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (1000),
        .MAX_RETRIES    (2)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Ps2ClkIn     (ps2_clk_s),
        .Ps2DataIn    (ps2_data_s),
        .Ps2ClkLowEn  (Ps2ClkLowEn),
        .Ps2DataLowEn (Ps2DataLowEn),
        .Write        (Write),
        .Data         (Data),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .ErrCode      (ErrCode)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Event monitors sampled on the falling edge.
    always @(negedge Clk) begin
        prev_clk_en <= Ps2ClkLowEn;
        if (Done) done_cnt <= done_cnt + 1;
        if (Error) begin
            err_cnt       <= err_cnt + 1;
            last_err_code <= ErrCode;
        end
        if (Ps2ClkLowEn && !prev_clk_en) attempt_cnt <= attempt_cnt + 1;
        if (Ps2ClkLowEn) begin
            inh_cnt <= inh_cnt + 1;
        end else if (prev_clk_en) begin
            last_inhibit_len <= inh_cnt;
            data_at_release  <= Ps2DataLowEn;
            inh_cnt          <= 0;
        end
        if (in_xfer && !Busy) busy_gap <= busy_gap + 1;
    end

    task automatic start_write(input logic [7:0] d);
        @(negedge Clk);
        Write = 1'b1;
        Data  = d;
        @(negedge Clk);
        Write = 1'b0;
        Data  = 8'h00;
    endtask

    // Device side: waits for RTS, then generates n_clk clocks, reading the line before each rise.
    task automatic dev_receive(input bit ack, input bit glitch, input int n_clk,
                               output logic [10:0] bits, output bit ok);
        int waited;
        ok     = 1'b0;
        bits   = '0;
        waited = 0;
        while (!(ps2_data_s === 1'b0 && ps2_clk_s === 1'b1) && waited < 12000) begin
            @(negedge Clk);
            waited++;
        end
        if (waited >= 12000) return;
        repeat (20) @(negedge Clk);
        bits[0] = ps2_data_s;
        for (int i = 1; i <= n_clk; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge Clk);
            if (i <= 10) bits[i] = ps2_data_s;
            dev_clk_low = 1'b0;
            if (i == 10 && ack) dev_data_low = 1'b1;
            if (glitch && i >= 2 && i <= 4) begin
                repeat (H / 2) @(negedge Clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge Clk);
                dev_clk_low = 1'b0;
                repeat (H - H / 2 - 3) @(negedge Clk);
            end else begin
                repeat (H) @(negedge Clk);
            end
            if (i == 11) dev_data_low = 1'b0;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        tests_run++;
        if ({Ps2ClkLowEn, Ps2DataLowEn, Busy, Done, Error, ErrCode} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {Ps2ClkLowEn, Ps2DataLowEn, Busy, Done, Error, ErrCode});
        end
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_basic();
        logic [10:0] b;
        bit ok;
        bit seen;
        int d0;
        d0 = done_cnt;
        start_write(8'hED);
        in_xfer = 1'b1;
        dev_receive(1'b1, 1'b0, 11, b, ok);
        tests_run++;
        if ({ok, b} !== {1'b1, 11'b111_1101_1010}) begin
            tests_failed++;
            $display("FAIL basic_bits: got ok=%0d bits=%b expected ok=1 bits=11111011010", ok, b);
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge Clk);
            if (Done) seen = 1'b1;
        end
        in_xfer = 1'b0;
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_done_seen: got %0d expected 1", seen);
        end
        @(negedge Clk);
        tests_run++;
        if (Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_after: got %b expected 0", Busy);
        end
        repeat (20) @(negedge Clk);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0);
        end
        tests_run++;
        if (busy_gap !== 0) begin
            tests_failed++;
            $display("FAIL basic_busy_held: got %0d low cycles expected 0", busy_gap);
        end
        tests_run++;
        if (last_inhibit_len !== 5000) begin
            tests_failed++;
            $display("FAIL inhibit_len: got %0d expected 5000", last_inhibit_len);
        end
        tests_run++;
        if (data_at_release !== 1'b1) begin
            tests_failed++;
            $display("FAIL rts_data_low: got %b expected 1", data_at_release);
        end
    endtask

    task automatic test_glitch();
        logic [10:0] b;
        bit ok;
        int d0;
        d0 = done_cnt;
        start_write(8'h5A);
        dev_receive(1'b1, 1'b1, 11, b, ok);
        tests_run++;
        if ({ok, b} !== {1'b1, 11'b110_1011_0100}) begin
            tests_failed++;
            $display("FAIL glitch_bits: got ok=%0d bits=%b expected ok=1 bits=11010110100", ok, b);
        end
        repeat (100) @(negedge Clk);
        tests_run++;
        if ({done_cnt - d0, Busy} !== {32'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL glitch_done: got done=%0d busy=%b expected done=1 busy=0", done_cnt - d0, Busy);
        end
    endtask

    task automatic test_write_ignored();
        int d0;
        d0 = done_cnt;
        start_write(8'h3C);
        fork
            dev_receive(1'b1, 1'b0, 11, bits_v, ok_v);
            begin
                repeat (5200) @(negedge Clk);
                Write = 1'b1;
                Data  = 8'h00;
                @(negedge Clk);
                Write = 1'b0;
            end
        join
        tests_run++;
        if ({ok_v, bits_v} !== {1'b1, 11'b110_0111_1000}) begin
            tests_failed++;
            $display("FAIL ignored_write_bits: got ok=%0d bits=%b expected ok=1 bits=11001111000", ok_v, bits_v);
        end
        repeat (100) @(negedge Clk);
        tests_run++;
        if ({done_cnt - d0, Busy} !== {32'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL ignored_write_done: got done=%0d busy=%b expected done=1 busy=0", done_cnt - d0, Busy);
        end
    endtask

    task automatic test_no_ack_retries();
        logic [10:0] b;
        bit ok;
        int d0, e0, a0, w;
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = attempt_cnt;
        start_write(8'hF4);
        for (int k = 0; k < 3; k++) begin
            dev_receive(1'b0, 1'b0, 11, b, ok);
            tests_run++;
            if ({ok, b} !== {1'b1, 11'b101_1110_1000}) begin
                tests_failed++;
                $display("FAIL noack_bits_%0d: got ok=%0d bits=%b expected ok=1 bits=10111101000", k, ok, b);
            end
        end
        w = 0;
        while (Busy && w < 2000) begin
            @(negedge Clk);
            w++;
        end
        repeat (200) @(negedge Clk);
        tests_run++;
        if (err_cnt - e0 !== 1 || last_err_code !== 2'b10) begin
            tests_failed++;
            $display("FAIL noack_error: got errors=%0d code=%b expected errors=1 code=10", err_cnt - e0, last_err_code);
        end
        tests_run++;
        if (attempt_cnt - a0 !== 3 || done_cnt - d0 !== 0) begin
            tests_failed++;
            $display("FAIL noack_attempts: got attempts=%0d done=%0d expected attempts=3 done=0",
                     attempt_cnt - a0, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int d0, e0, a0, w;
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = attempt_cnt;
        start_write(8'h55);
        w = 0;
        while (Busy && w < 25000) begin
            @(negedge Clk);
            w++;
        end
        tests_run++;
        if (Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_finish: got busy=%b after %0d cycles expected 0", Busy, w);
        end
        repeat (2) @(negedge Clk);
        tests_run++;
        if (err_cnt - e0 !== 1 || last_err_code !== 2'b01 || ErrCode !== 2'b01) begin
            tests_failed++;
            $display("FAIL timeout_error: got errors=%0d code=%b held=%b expected 1 01 01",
                     err_cnt - e0, last_err_code, ErrCode);
        end
        tests_run++;
        if (attempt_cnt - a0 !== 3 || done_cnt - d0 !== 0) begin
            tests_failed++;
            $display("FAIL timeout_attempts: got attempts=%0d done=%0d expected 3 0", attempt_cnt - a0, done_cnt - d0);
        end
        tests_run++;
        if ({Ps2ClkLowEn, Ps2DataLowEn} !== 2'b00) begin
            tests_failed++;
            $display("FAIL timeout_lines: got %b expected 00", {Ps2ClkLowEn, Ps2DataLowEn});
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [10:0] b;
        bit ok;
        int d0, e0;
        start_write(8'hA5);
        tests_run++;
        if (ErrCode !== 2'b00) begin
            tests_failed++;
            $display("FAIL errcode_clear: got %b expected 00", ErrCode);
        end
        dev_receive(1'b0, 1'b0, 5, b, ok);
        tests_run++;
        if ({ok, Busy, Ps2ClkLowEn, Ps2DataLowEn} !== 4'b1101) begin
            tests_failed++;
            $display("FAIL midshift_state: got %b expected 1101", {ok, Busy, Ps2ClkLowEn, Ps2DataLowEn});
        end
        d0 = done_cnt;
        e0 = err_cnt;
        Reset = 1'b1;
        #1;
        tests_run++;
        if ({Ps2ClkLowEn, Ps2DataLowEn, Busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_release: got %b expected 000", {Ps2ClkLowEn, Ps2DataLowEn, Busy});
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (1500) @(negedge Clk);
        tests_run++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_pulse: got done=%0d err=%0d busy=%b expected 0 0 0",
                     done_cnt - d0, err_cnt - e0, Busy);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        done_cnt      = 0;
        err_cnt       = 0;
        attempt_cnt   = 0;
        inh_cnt       = 0;
        busy_gap      = 0;
        last_inhibit_len = 0;
        last_err_code = 2'b00;
        prev_clk_en   = 1'b0;
        data_at_release = 1'b0;
        in_xfer       = 1'b0;
        Write         = 1'b0;
        Data          = 8'h00;
        dev_clk_low   = 1'b0;
        dev_data_low  = 1'b0;
        Reset         = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_write_ignored();
        test_no_ack_retries();
        test_timeout();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
